data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Sequences single accumulator load/store requests onto a synchronous data
//   memory whose read data arrives MEM_LATENCY cycles after the access strobe.
//   One request is in flight at a time; requests are only accepted in IDLE.
//
// Ports
//   clock, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_write     : request strobe and op select (1 = store, 0 = load)
//   req_addr/req_wdata      : request address and store data
//   req_ready/busy          : controller idle (accepting) / its complement
//   rsp_valid/rsp_rdata     : one-cycle load completion pulse and held load data
//   mem_en/mem_we           : memory access strobe and write enable
//   mem_addr/mem_wdata      : memory address and write data (held between accesses)
//   mem_rdata               : memory read data
module data_mem_ctrl #(
  parameter int DATA_WIDTH  = 11,
  parameter int ADDR_WIDTH  = 11,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // WAIT lasts MEM_LATENCY cycles: the counter starts at MEM_LATENCY-1 and
  // the read data is captured on the edge where it has reached zero.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic                    rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Latch the whole request so later input changes cannot leak in.
          we_d     = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          mem_en_d = 1'b1;
          mem_we_d = req_write;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d     = mem_rdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Address/write data come straight from the latched request, so they hold
  // their last value outside ACCESS without extra muxing.
  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule
